// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK cells: it accepts one op/mask/count command
// and applies the op to the masked cells once per clock until the count runs out or an abort arrives.
module jk_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] remaining;
  logic             aborted_r;
  logic             accept;
  logic             apply;
  logic             abort_hit;

  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                               input logic [1:0]       op,
                                               input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] t;
    case (op)
      2'b00:   t = cur;
      2'b01:   t = '0;
      2'b10:   t = '1;
      default: t = ~cur;
    endcase
    return (t & mask) | (cur & ~mask);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    apply     = 1'b0;
    abort_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over the application scheduled for this edge.
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          apply = 1'b1;
          if (remaining == CNT_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= abort_hit;
      if (accept)     remaining <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
      else if (apply) remaining <= remaining - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= cmd_op;
      mask_r <= cmd_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (apply) q <= jk_next(q, op_r, mask_r);
  end

  assign qn        = ~q;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign aborted   = aborted_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a command table checked against a scoreboard of expected q values,
// plus hand-written sequences for the handshake, abort and mid-run reset.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_count(cmd_count), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .q(q), .qn(qn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_HOLD = 2'b00, OP_RESET = 2'b01, OP_SET = 2'b10, OP_TOG = 2'b11;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] exp_final;
  } vec_t;

  vec_t             vecs[7];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mq;
  int               checks;
  int               errors;
  int               acc_cnt;

  always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

  function automatic logic [WIDTH-1:0] model_jk(input logic [WIDTH-1:0] cur,
                                                input logic [1:0] op,
                                                input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] r;
    r = cur;
    for (int b = 0; b < WIDTH; b++) begin
      if (mask[b]) begin
        if (op == OP_RESET)    r[b] = 1'b0;
        else if (op == OP_SET) r[b] = 1'b1;
        else if (op == OP_TOG) r[b] = ~cur[b];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                         input logic [CNT_W-1:0] count);
    int n;
    logic [WIDTH-1:0] eq;
    n = (count == 0) ? 1 : int'(count);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = count;
    for (int k = 0; k < n; k++) begin
      mq = model_jk(mq, op, mask);
      exp_q.push_back(mq);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_mask  = '0;
    cmd_count = '0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      eq = exp_q.pop_front();
      check("q_step", {24'd0, q}, {24'd0, eq});
      check("qn_step", {24'd0, qn}, {24'd0, ~eq});
      if (k < n) begin
        check("busy_run", {30'd0, busy, done}, 32'b10);
      end else begin
        check("done_pulse", {28'd0, done, aborted, busy, cmd_ready}, 32'b1000);
      end
    end
    @(posedge clk); #1;
    check("ready_after_done", {30'd0, cmd_ready, done}, 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    acc_cnt   = 0;
    mq        = '0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_mask  = '0;
    cmd_count = '0;
    abort     = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = '{OP_SET,   8'hA5, 8'd1,   8'hA5};
    vecs[1] = '{OP_TOG,   8'h0F, 8'd3,   8'hAA};
    vecs[2] = '{OP_RESET, 8'h80, 8'd0,   8'h2A};
    vecs[3] = '{OP_HOLD,  8'hFF, 8'd2,   8'h2A};
    vecs[4] = '{OP_SET,   8'h00, 8'd2,   8'h2A};
    vecs[5] = '{OP_TOG,   8'hFF, 8'd1,   8'hD5};
    vecs[6] = '{OP_TOG,   8'h01, 8'd255, 8'hD4};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {8'd0, q, qn, 4'd0, cmd_ready, busy, done, aborted},
          {8'd0, 8'h00, 8'hFF, 4'd0, 4'b1000});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_release", {16'd0, q, 4'd0, cmd_ready, busy, done, aborted}, {16'd0, 8'h00, 4'd0, 4'b1000});

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].op, vecs[i].mask, vecs[i].count);
      check("vec_final", {24'd0, q}, {24'd0, vecs[i].exp_final});
    end

    // cmd_valid held high with changing payloads across a count=4 command.
    wait_ready();
    acc_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_op    = OP_RESET;
    cmd_mask  = 8'hFF;
    cmd_count = 8'd4;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_op    = OP_SET;
      cmd_mask  = 8'(k * 37);
      cmd_count = 8'd1;
      check("no_accept_busy", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    cmd_mask = 8'h3C;
    check("held_done_q", {23'd0, q, done}, {23'd0, 8'h00, 1'b1});
    check("no_accept_done", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_again", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("second_accept_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("second_cmd_q", {23'd0, q, done}, {23'd0, 8'h3C, 1'b1});
    check("accept_count", acc_cnt, 32'd2);
    mq = 8'h3C;

    // Clear the bank, then abort a long toggle on its third RUN edge.
    run_cmd(OP_RESET, 8'hFF, 8'd1);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = OP_TOG;
    cmd_mask  = 8'h01;
    cmd_count = 8'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_t1", {24'd0, q}, 32'h01);
    @(posedge clk); #1;
    check("abort_t2", {24'd0, q}, 32'h00);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done", {20'd0, q, done, aborted, busy, cmd_ready}, {20'd0, 8'h00, 4'b1100});
    @(posedge clk); #1;
    check("abort_clear", {29'd0, done, aborted, cmd_ready}, 32'b001);

    // Same command, reset asserted mid-run between clock edges.
    wait_ready();
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_q", {24'd0, q}, 32'h01);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {12'd0, q, qn, cmd_ready, busy, done, aborted},
          {12'd0, 8'h00, 8'hFF, 4'b1000});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {22'd0, q, cmd_ready, busy}, {22'd0, 8'h00, 2'b10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
